// File: rtl/audio_out_if.sv
// Sample/control/output bundle between the sound generator, the output stage and the pin.
interface audio_out_if;
    logic       sample_ena;
    logic [3:0] sample;
    logic       enable;
    logic       pdm_out;
    logic [7:0] level;
    logic       muted;

    modport master (output sample_ena, sample, enable, input pdm_out, level, muted);
    modport slave  (input sample_ena, sample, enable, output pdm_out, level, muted);
endinterface

// File: rtl/audio_out_stage.sv
// Sample latch, faded master volume and first-order sigma-delta PDM output.
module audio_out_stage #(
    parameter int FADE_STEP_SAMPLES = 64
) (
    input  logic        clock,
    input  logic        reset,
    audio_out_if.slave  bus
);
    localparam int FW = $clog2(FADE_STEP_SAMPLES);
    localparam logic [FW-1:0] STEP_LAST = FW'(FADE_STEP_SAMPLES - 1);

    typedef enum logic [1:0] {MUTED, FADE_IN, PLAY, FADE_OUT} state_t;

    state_t        state;
    logic [3:0]    cur;
    logic [3:0]    vol;
    logic [FW-1:0] fc;
    logic [7:0]    acc;
    logic [7:0]    level;
    logic          pdm;
    logic          muted;
    logic          step;
    logic [8:0]    sum;

    assign step = bus.sample_ena && (fc == STEP_LAST);
    assign sum  = {1'b0, acc} + {1'b0, level};

    assign bus.level   = level;
    assign bus.pdm_out = pdm;
    assign bus.muted   = muted;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= MUTED;
            cur   <= 4'd0;
            vol   <= 4'd0;
            fc    <= '0;
            acc   <= 8'd0;
            level <= 8'd0;
            pdm   <= 1'b0;
            muted <= 1'b1;
        end else begin
            if (bus.sample_ena)
                cur <= bus.sample;
            level <= {4'd0, cur} * {4'd0, vol};
            acc   <= sum[7:0];
            pdm   <= sum[8];

            // An enable reversal wins over a coincident step: direction flips, vol holds.
            case (state)
                MUTED: begin
                    if (bus.enable) begin
                        state <= FADE_IN;
                        muted <= 1'b0;
                        fc    <= '0;
                    end
                end
                FADE_IN: begin
                    if (!bus.enable) begin
                        state <= FADE_OUT;
                        fc    <= '0;
                    end else if (step) begin
                        fc <= '0;
                        if (vol >= 4'd14) begin
                            vol   <= 4'd15;
                            state <= PLAY;
                        end else begin
                            vol <= vol + 4'd1;
                        end
                    end else if (bus.sample_ena) begin
                        fc <= fc + 1'b1;
                    end
                end
                PLAY: begin
                    if (!bus.enable) begin
                        state <= FADE_OUT;
                        fc    <= '0;
                    end
                end
                FADE_OUT: begin
                    if (bus.enable) begin
                        state <= FADE_IN;
                        fc    <= '0;
                    end else if (step) begin
                        fc <= '0;
                        if (vol <= 4'd1) begin
                            vol   <= 4'd0;
                            state <= MUTED;
                            muted <= 1'b1;
                        end else begin
                            vol <= vol - 4'd1;
                        end
                    end else if (bus.sample_ena) begin
                        fc <= fc + 1'b1;
                    end
                end
                default: begin
                    state <= MUTED;
                    muted <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_audio_out_stage.sv
// Directed test-plan phases plus random traffic, checked every cycle against a behavioural model.
module tb_audio_out_stage;
    localparam int N = 2;

    logic clock = 1'b0;
    logic reset;
    audio_out_if bus();

    audio_out_stage #(.FADE_STEP_SAMPLES(N)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: volume moves toward a target one unit per N pulses.
    int m_vol, m_dir, m_pulses, m_cur, m_level, m_acc, m_pdm;
    bit m_muted;

    always @(posedge clock) begin
        int s;
        if (reset) begin
            m_vol = 0; m_dir = 0; m_pulses = 0; m_cur = 0;
            m_level = 0; m_acc = 0; m_pdm = 0;
        end else begin
            s = m_acc + m_level;
            m_pdm = s / 256;
            m_acc = s % 256;
            m_level = m_cur * m_vol;
            if (bus.sample_ena) m_cur = int'(bus.sample);
            if (m_dir == 0) begin
                if (m_vol == 0 && bus.enable) begin m_dir = 1; m_pulses = 0; end
                else if (m_vol == 15 && !bus.enable) begin m_dir = -1; m_pulses = 0; end
            end else if ((m_dir > 0) != bus.enable) begin
                m_dir = bus.enable ? 1 : -1;
                m_pulses = 0;
            end else if (bus.sample_ena) begin
                m_pulses++;
                if (m_pulses == N) begin
                    m_pulses = 0;
                    m_vol = m_vol + m_dir;
                    if (m_vol > 15) m_vol = 15;
                    if (m_vol < 0) m_vol = 0;
                    if ((m_dir > 0 && m_vol == 15) || (m_dir < 0 && m_vol == 0)) m_dir = 0;
                end
            end
        end
        m_muted = (m_dir == 0 && m_vol == 0);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    always @(negedge clock) begin
        chk("level", int'(bus.level), m_level);
        chk("muted", int'(bus.muted), int'(m_muted));
        chk("pdm_out", int'(bus.pdm_out), m_pdm);
    end

    task automatic pulse(input int smp);
        bus.sample = 4'(smp);
        bus.sample_ena = 1'b1;
        @(negedge clock);
        bus.sample_ena = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic count_ones(input int cycles, output int ones);
        ones = 0;
        repeat (cycles) begin
            @(negedge clock);
            ones += int'(bus.pdm_out);
        end
    endtask

    initial begin
        int ones;
        reset = 1'b1;
        bus.enable = 1'b1;
        bus.sample = 4'd15;
        bus.sample_ena = 1'b1;

        // Reset held with enable and full-scale sample present
        repeat (3) begin
            @(negedge clock);
            chk("rst_level", int'(bus.level), 0);
            chk("rst_pdm", int'(bus.pdm_out), 0);
            chk("rst_muted", int'(bus.muted), 1);
        end
        bus.sample_ena = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        chk("leave_muted", int'(bus.muted), 0);

        // Fade in: 30 pulses to full volume
        repeat (29) pulse(15);
        chk("pre_play_level", int'(bus.level), 210);
        pulse(15);
        chk("play_level", int'(bus.level), 225);
        count_ones(256, ones);
        chk_rng("density_225", ones, 224, 226);

        // Fade out: 30 pulses to mute, then silence
        bus.enable = 1'b0;
        @(negedge clock);
        repeat (30) pulse(15);
        chk("fadeout_muted", int'(bus.muted), 1);
        chk("fadeout_level", int'(bus.level), 0);
        count_ones(64, ones);
        chk("silent_ones", ones, 0);

        // Reversal at vol=7 coincident with a step event
        bus.enable = 1'b1;
        @(negedge clock);
        repeat (15) pulse(15);
        chk("rev_vol7", int'(bus.level), 105);
        bus.enable = 1'b0;
        pulse(15);
        chk("rev_hold7", int'(bus.level), 105);
        pulse(15);
        chk("rev_still7", int'(bus.level), 105);
        pulse(15);
        chk("rev_vol6", int'(bus.level), 90);

        // Drain, then fade in with sample 8 for density
        repeat (12) pulse(15);
        chk("rev_drained", int'(bus.muted), 1);
        bus.enable = 1'b1;
        @(negedge clock);
        repeat (30) pulse(8);
        chk("d_level", int'(bus.level), 120);
        count_ones(512, ones);
        chk_rng("density_120", ones, 239, 241);

        // Mid-fade reset at vol=9
        bus.enable = 1'b0;
        @(negedge clock);
        repeat (12) pulse(8);
        chk("mid_vol9", int'(bus.level), 72);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("mid_rst_level", int'(bus.level), 0);
        chk("mid_rst_muted", int'(bus.muted), 1);
        chk("mid_rst_pdm", int'(bus.pdm_out), 0);

        // Random traffic
        for (int i = 0; i < 6000; i++) begin
            bus.sample_ena = ($urandom_range(0, 3) == 0);
            bus.sample = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 149) == 0) bus.enable = ~bus.enable;
            reset = ($urandom_range(0, 1999) == 0);
            @(negedge clock);
        end
        reset = 1'b0;
        bus.sample_ena = 1'b0;
        @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
